// File: rtl/multi_cycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath that feeds it.
interface multi_cycle_control_fsm_if #(
  parameter int kRetireCntWidth = 32
);
  logic [6:0]                 opcode;
  logic                       bcond;
  logic                       mem_ready;
  logic                       pc_write;
  logic                       pc_source;
  logic                       i_or_d;
  logic                       mem_read;
  logic                       mem_write;
  logic                       ir_write;
  logic                       reg_write;
  logic [1:0]                 mem_to_reg;
  logic                       alu_src_a;
  logic [1:0]                 alu_src_b;
  logic [1:0]                 alu_op;
  logic                       halted;
  logic                       illegal;
  logic                       inst_retire;
  logic [kRetireCntWidth-1:0] retire_count;

  modport master (
    input  opcode, bcond, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           halted, illegal, inst_retire, retire_count
  );

  modport slave (
    output opcode, bcond, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           halted, illegal, inst_retire, retire_count
  );
endinterface

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: IF/ID/EX/MEM/WB walk, memory-ready stalls,
// sticky halt/illegal flags and a wrapping retired-instruction counter.
module multi_cycle_control_fsm #(
  parameter int kRetireCntWidth = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_cycle_control_fsm_if.master bus
);

  typedef enum logic [4:0] {
    S_IDLE, S_IF, S_ID, S_EX_R, S_EX_I, S_WB_ALU, S_MEM_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_EX_BR, S_BR_TAKEN, S_PC_INC, S_EX_JAL, S_EX_JALR,
    S_LINK, S_HALT
  } state_e;

  localparam logic [6:0] kOpR      = 7'b0110011;
  localparam logic [6:0] kOpI      = 7'b0010011;
  localparam logic [6:0] kOpLoad   = 7'b0000011;
  localparam logic [6:0] kOpStore  = 7'b0100011;
  localparam logic [6:0] kOpBranch = 7'b1100011;
  localparam logic [6:0] kOpJal    = 7'b1101111;
  localparam logic [6:0] kOpJalr   = 7'b1100111;
  localparam logic [6:0] kOpSystem = 7'b1110011;

  localparam logic [kRetireCntWidth-1:0] kCntOne = {{(kRetireCntWidth-1){1'b0}}, 1'b1};

  state_e                     r_state;
  state_e                     w_next;
  logic                       r_illegal;
  logic [kRetireCntWidth-1:0] r_retire_count;

  logic       w_set_illegal;
  logic       w_pc_inc;
  logic       w_pc_write;
  logic       w_pc_source;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;

  // NOTE: state lives only here and uses non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_illegal      <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_pc_write)    r_retire_count <= r_retire_count + kCntOne;
    end
  end

  always_comb begin
    // NOTE: every signal is defaulted before the case so no path infers a latch.
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_pc_inc      = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_source   = 1'b0;
    w_i_or_d      = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_to_reg  = 2'b00;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_op      = 2'b00;

    unique case (r_state)
      S_IDLE: w_next = S_IF;
      S_IF: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_ID;
        end
      end
      S_ID: begin
        case (bus.opcode)
          kOpR:              w_next = S_EX_R;
          kOpI:              w_next = S_EX_I;
          kOpLoad, kOpStore: w_next = S_MEM_ADDR;
          kOpBranch:         w_next = S_EX_BR;
          kOpJal:            w_next = S_EX_JAL;
          kOpJalr:           w_next = S_EX_JALR;
          kOpSystem:         w_next = S_HALT;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_EX_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_next      = S_WB_ALU;
      end
      S_EX_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b01;
        w_next      = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
        w_pc_inc    = 1'b1;
        w_next      = S_IF;
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.opcode == kOpLoad) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (bus.mem_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b01;
        w_pc_inc     = 1'b1;
        w_next       = S_IF;
      end
      // The store commits and PC advances in the same cycle memory accepts it.
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          w_pc_inc = 1'b1;
          w_next   = S_IF;
        end
      end
      S_EX_BR: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = bus.bcond ? S_BR_TAKEN : S_PC_INC;
      end
      S_BR_TAKEN: begin
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_IF;
      end
      S_PC_INC: begin
        w_pc_inc = 1'b1;
        w_next   = S_IF;
      end
      S_EX_JAL: begin
        w_alu_src_b = 2'b10;
        w_next      = S_LINK;
      end
      S_EX_JALR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_LINK;
      end
      // Jump target already sits in ALUOut; the ALU is free to form the link PC+4.
      S_LINK: begin
        w_alu_src_b  = 2'b01;
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b10;
        w_pc_write   = 1'b1;
        w_pc_source  = 1'b1;
        w_next       = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase

    if (w_pc_inc) begin
      w_pc_write  = 1'b1;
      w_alu_src_b = 2'b01;
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.pc_source    = w_pc_source;
  assign bus.i_or_d       = w_i_or_d;
  assign bus.mem_read     = w_mem_read;
  assign bus.mem_write    = w_mem_write;
  assign bus.ir_write     = w_ir_write;
  assign bus.reg_write    = w_reg_write;
  assign bus.mem_to_reg   = w_mem_to_reg;
  assign bus.alu_src_a    = w_alu_src_a;
  assign bus.alu_src_b    = w_alu_src_b;
  assign bus.alu_op       = w_alu_op;
  assign bus.halted       = (r_state == S_HALT);
  assign bus.illegal      = r_illegal;
  assign bus.inst_retire  = w_pc_write;
  assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Scoreboard bench: an instruction-level model expands each instruction into its
// expected per-cycle control vectors; a monitor compares them at every falling edge.
module tb_multi_cycle_control_fsm;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal;
    logic       inst_retire;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       exp;
    logic [31:0] cnt;
  } entry_t;

  logic clk;
  logic reset;

  multi_cycle_control_fsm_if #(.kRetireCntWidth(32)) bus ();

  multi_cycle_control_fsm #(.kRetireCntWidth(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] model_cnt = '0;
  entry_t      q[$];
  entry_t      mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t get_ctrl();
    ctrl_t c;
    c.pc_write    = bus.pc_write;
    c.pc_source   = bus.pc_source;
    c.i_or_d      = bus.i_or_d;
    c.mem_read    = bus.mem_read;
    c.mem_write   = bus.mem_write;
    c.ir_write    = bus.ir_write;
    c.reg_write   = bus.reg_write;
    c.mem_to_reg  = bus.mem_to_reg;
    c.alu_src_a   = bus.alu_src_a;
    c.alu_src_b   = bus.alu_src_b;
    c.alu_op      = bus.alu_op;
    c.halted      = bus.halted;
    c.illegal     = bus.illegal;
    c.inst_retire = bus.inst_retire;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic ctrl_t alu(input logic a, input logic [1:0] b, input logic [1:0] op);
    ctrl_t c = '0;
    c.alu_src_a = a;
    c.alu_src_b = b;
    c.alu_op    = op;
    return c;
  endfunction

  // PC <= PC + 4 through the ALU; every such cycle retires an instruction.
  function automatic ctrl_t pc4();
    ctrl_t c = alu(1'b0, 2'b01, 2'b00);
    c.pc_write    = 1'b1;
    c.inst_retire = 1'b1;
    return c;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what must be seen.
  task automatic step(input logic mr, input logic bc, input ctrl_t exp);
    entry_t e;
    @(posedge clk);
    #1;
    bus.mem_ready = mr;
    bus.bcond     = bc;
    e.exp = exp;
    e.cnt = model_cnt;
    q.push_back(e);
    if (exp.inst_retire) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic exec(input logic [6:0] op, input int w_if, input int w_mem, input logic bc);
    ctrl_t c;
    bus.opcode = op;
    c = '0;
    c.mem_read = 1'b1;
    for (int i = 0; i < w_if; i++) step(1'b0, rb(), c);
    c.ir_write = 1'b1;
    step(1'b1, rb(), c);
    step(rb(), rb(), '0);
    case (op)
      OP_R, OP_I: begin
        step(rb(), rb(), alu(1'b1, (op == OP_R) ? 2'b00 : 2'b10, 2'b01));
        c = pc4();
        c.reg_write = 1'b1;
        step(rb(), rb(), c);
      end
      OP_LD: begin
        step(rb(), rb(), alu(1'b1, 2'b10, 2'b00));
        c = '0;
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        for (int i = 0; i < w_mem; i++) step(1'b0, rb(), c);
        step(1'b1, rb(), c);
        c = pc4();
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
        step(rb(), rb(), c);
      end
      OP_ST: begin
        step(rb(), rb(), alu(1'b1, 2'b10, 2'b00));
        c = '0;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        for (int i = 0; i < w_mem; i++) step(1'b0, rb(), c);
        c = pc4();
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        step(1'b1, rb(), c);
      end
      OP_BR: begin
        step(rb(), bc, alu(1'b1, 2'b00, 2'b10));
        if (bc) begin
          c = alu(1'b0, 2'b10, 2'b00);
          c.pc_write    = 1'b1;
          c.inst_retire = 1'b1;
        end else begin
          c = pc4();
        end
        step(rb(), rb(), c);
      end
      OP_JAL, OP_JALR: begin
        step(rb(), rb(), alu(op == OP_JALR, 2'b10, 2'b00));
        c = pc4();
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b10;
        c.pc_source  = 1'b1;
        step(rb(), rb(), c);
      end
      default: ;  // system or unknown opcode: the machine halts after ID
    endcase
  endtask

  task automatic halt_cycles(input int n, input logic ill);
    ctrl_t c = '0;
    c.halted  = 1'b1;
    c.illegal = ill;
    for (int i = 0; i < n; i++) step(rb(), rb(), c);
  endtask

  // Assert reset asynchronously mid-cycle and expect outputs to clear immediately.
  task automatic async_reset(input string name);
    #6;
    reset = 1'b1;
    #1;
    check({name, " ctrl"}, 64'(get_ctrl()), 64'(0));
    check({name, " retire_count"}, 64'(bus.retire_count), 64'(0));
    model_cnt = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    entry_t e;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.mem_ready = rb();
    e.exp = '0;
    e.cnt = model_cnt;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check($sformatf("cycle %0d ctrl", cyc), 64'(get_ctrl()), 64'(mon_e.exp));
        check($sformatf("cycle %0d retire_count", cyc), 64'(bus.retire_count), 64'(mon_e.cnt));
      end
    end
  end

  logic [6:0] legal_ops [7];
  ctrl_t      c_tmp;

  initial begin
    legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
    reset         = 1'b0;
    bus.opcode    = '0;
    bus.bcond     = 1'b0;
    bus.mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("power-on reset ctrl", 64'(get_ctrl()), 64'(0));
    check("power-on reset retire_count", 64'(bus.retire_count), 64'(0));
    release_reset();

    exec(OP_R,    0, 0, 1'b0);
    exec(OP_LD,   0, 2, 1'b0);
    exec(OP_BR,   0, 0, 1'b1);
    exec(OP_BR,   0, 0, 1'b0);
    exec(OP_JALR, 0, 0, 1'b0);
    exec(OP_JAL,  1, 0, 1'b0);
    exec(OP_ST,   1, 2, 1'b0);
    exec(OP_I,    2, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      exec(legal_ops[$urandom_range(6, 0)], $urandom_range(2, 0), $urandom_range(3, 0), rb());
    end

    // Load stalled in MEM_RD, then reset lands in the middle of the stall.
    bus.opcode = OP_LD;
    c_tmp = '0;
    c_tmp.mem_read = 1'b1;
    c_tmp.ir_write = 1'b1;
    step(1'b1, rb(), c_tmp);
    step(rb(), rb(), '0);
    step(rb(), rb(), alu(1'b1, 2'b10, 2'b00));
    c_tmp = '0;
    c_tmp.mem_read = 1'b1;
    c_tmp.i_or_d   = 1'b1;
    step(1'b0, rb(), c_tmp);
    async_reset("mid-MEM_RD reset");
    release_reset();

    exec(OP_R, 0, 0, 1'b0);
    exec(OP_SYS, 0, 0, 1'b0);
    halt_cycles(6, 1'b0);
    async_reset("reset out of HALT");
    release_reset();

    exec(7'h7F, 1, 0, 1'b0);
    halt_cycles(6, 1'b1);
    async_reset("reset after illegal");
    release_reset();

    exec(OP_ST, 0, 1, 1'b0);
    exec(7'h00, 0, 0, 1'b0);
    halt_cycles(4, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_fsm.md
Name: multi_cycle_control_fsm

Overview:
Control sequencer for the multi-cycle RV32I datapath. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives all datapath mux selects, including the 2-bit ALU operand-B select into the 4:1 mux, plus the register/memory write enables. It stalls on a memory ready handshake and keeps a retired-instruction counter.

Parameters:
kRetireCntWidth, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0] from instruction register
bcond  input  1  branch-compare result from ALU (valid in EX_BR)
mem_ready  input  1  memory completes current read/write this cycle
pc_write  output  1  PC register load enable
pc_source  output  1  0 = ALU result, 1 = ALUOut register
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load enable
reg_write  output  1  register file write enable
mem_to_reg  output  2  writeback data: 00 = ALUOut, 01 = MDR, 10 = ALU result, 11 reserved
alu_src_a  output  1  0 = PC, 1 = A (rs1)
alu_src_b  output  2  00 = B (rs2), 01 = constant 4, 10 = immediate, 11 unused (never driven)
alu_op  output  2  00 = ADD, 01 = by funct, 10 = branch compare
halted  output  1  sticky; high in HALT
illegal  output  1  sticky; high when halt was caused by an unknown opcode
inst_retire  output  1  one-cycle pulse when an instruction commits
retire_count  output  kRetireCntWidth  number of retired instructions

Behaviour:
- Reset (async, any state, any time): state becomes IDLE, retire_count = 0, halted = 0, illegal = 0.
- In IDLE every output is 0; IDLE always goes to IF on the next clock.
- Outputs are decoded combinationally from state. Any output not listed for a state is 0.
- IF: mem_read=1, i_or_d=0. Stay in IF while mem_ready=0. When mem_ready=1: ir_write=1, next state ID.
- ID: no enables. Next state by opcode:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> EX_BR
  - 1101111 -> EX_JAL
  - 1100111 -> EX_JALR
  - 1110011 -> HALT
  - any other opcode -> HALT with illegal set
- EX_R: alu_src_a=1, alu_src_b=00, alu_op=01 -> WB_ALU.
- EX_I: alu_src_a=1, alu_src_b=10, alu_op=01 -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=00. PC+4: alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0, pc_write=1. -> IF.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold while mem_ready=0; on mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=01, PC+4 update as in WB_ALU -> IF.
- MEM_WR: mem_write=1, i_or_d=1. Hold while mem_ready=0. On mem_ready: PC+4 update in the same cycle -> IF.
- EX_BR: alu_src_a=1, alu_src_b=00, alu_op=10. bcond=1 -> BR_TAKEN; bcond=0 -> PC_INC.
- BR_TAKEN: alu_src_a=0, alu_src_b=10, alu_op=00, pc_source=0, pc_write=1 -> IF.
- PC_INC: PC+4 update -> IF.
- EX_JAL: alu_src_a=0, alu_src_b=10, ADD -> LINK.
- EX_JALR: alu_src_a=1, alu_src_b=10, ADD -> LINK.
- LINK: ALU computes PC+4 (alu_src_a=0, alu_src_b=01, ADD). reg_write=1, mem_to_reg=10, pc_write=1, pc_source=1 (target taken from ALUOut). rs1 is already consumed, so rd==rs1 is safe.
- HALT: absorbing until reset; halted=1; no memory requests.
- inst_retire = pc_write. retire_count increments by 1 on each inst_retire and wraps modulo 2^kRetireCntWidth.
- Latency with mem_ready always 1:
  - R, I, store, branch, JAL, JALR: 4 cycles
  - load: 5 cycles
  - each cycle of mem_ready=0 in IF, MEM_RD or MEM_WR adds 1 cycle.
- mem_ready is ignored outside IF, MEM_RD and MEM_WR.

Test Plan:
- Reset asserted mid-MEM_RD with mem_ready=0 -> outputs all 0 immediately (async), retire_count=0. After release: 1 IDLE cycle, then IF with mem_read=1, i_or_d=0.
- ADD (opcode 0110011), mem_ready=1 -> states IF, ID, EX_R, WB_ALU. alu_src_b=00 in EX_R, then 01 in WB_ALU. reg_write and inst_retire for exactly 1 cycle; retire_count=1.
- LW, with mem_ready low for 2 cycles in MEM_RD -> mem_read=1, i_or_d=1 held for 3 cycles. WB_MEM has mem_to_reg=01; total 7 cycles.
- BEQ twice, bcond=1 then bcond=0 -> BR_TAKEN with alu_src_b=10, then PC_INC with alu_src_b=01. Each instruction takes 4 cycles; retire_count=2.
- JALR (opcode 1100111) -> EX_JALR has alu_src_a=1, alu_src_b=10. LINK has reg_write=1, mem_to_reg=10, pc_source=1, pc_write=1 in the same cycle.
- ECALL (1110011) -> halted=1, illegal=0, no further mem_read. After reset, opcode 7'h7F -> halted=1 and illegal=1.
